btn_debounce_onehot: RTL and testbench

- Four-channel pushbutton conditioner that sits directly upstream of the one-hot-to-binary selector encoder.
- Each raw button input is synchronised and debounced with a counter.
- A qualified press produces a single-cycle one-hot pulse. The encoder consumes the pulse to form a 2-bit selection code.
- At most one bit of the pulse output is ever set, so the downstream encoder never sees a multi-hot code.

---
 rtl/btn_debounce_onehot_if.sv | 23 ++
 rtl/btn_debounce_onehot.sv | 144 ++++++++++++++
 tb/tb_btn_debounce_onehot.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_onehot_if.sv
// Button conditioner bus: raw button levels in, debounced levels and one-hot press pulse out.
interface btn_debounce_onehot_if;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] sel_pulse;
    logic       sel_valid;

    // Driver of the raw buttons, consumer of the conditioned outputs.
    modport master (
        output btn_in,
        input  btn_level,
        input  sel_pulse,
        input  sel_valid
    );

    // The conditioner itself.
    modport slave (
        input  btn_in,
        output btn_level,
        output sel_pulse,
        output sel_valid
    );
endinterface

// File: rtl/btn_debounce_onehot.sv
// Four-channel pushbutton conditioner feeding a one-hot-to-binary selector encoder.
// Each button is synchronised (2 flops), debounced by a per-channel counter FSM, and a
// qualified press raises a one-cycle request. Coincident requests are resolved to the
// lowest index in a registered output stage, so sel_pulse is never multi-hot.
// Optional feature: define AUTO_REPEAT_EN to add hold-to-repeat press requests.
module btn_debounce_onehot #(
    parameter int unsigned CNT_MAX       = 1_000_000,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 20_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    btn_debounce_onehot_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic [1:0] {StIdle, StArming, StPressed, StDisarming} state_e;

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    state_e           state_q [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [3:0]       level_q;
    logic [3:0]       req_q;
    logic [3:0]       sel_pulse_q;
    logic             sel_valid_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q [4];
    logic [3:0]       rpt_first_q;  // first repeat already issued -> use the period
`else
    // Repeat timing only matters when the repeat feature is built in.
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // Two-flop synchroniser per button.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce FSM; the counter only advances while a level change is pending
    // and stops at CNT_LAST, so it can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
`ifdef AUTO_REPEAT_EN
                rpt_cnt_q[i] <= '0;
`endif
            end
            level_q <= '0;
            req_q   <= '0;
`ifdef AUTO_REPEAT_EN
            rpt_first_q <= '0;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                req_q[i] <= 1'b0;
                case (state_q[i])
                    StIdle: begin
                        level_q[i] <= 1'b0;
                        if (sync2_q[i]) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= StArming;
                        end
                    end
                    StArming: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= StIdle;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i] <= StPressed;
                            level_q[i] <= 1'b1;
                            req_q[i]   <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    StPressed: begin
                        level_q[i] <= 1'b1;
                        if (!sync2_q[i]) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= StDisarming;
`ifdef AUTO_REPEAT_EN
                            // Clearing on exit guarantees a fresh delay on any re-entry.
                            rpt_cnt_q[i]   <= '0;
                            rpt_first_q[i] <= 1'b0;
                        end else if (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_PERIOD_LAST
                                                                     : RPT_DELAY_LAST)) begin
                            req_q[i]       <= 1'b1;
                            rpt_cnt_q[i]   <= '0;
                            rpt_first_q[i] <= 1'b1;
                        end else begin
                            rpt_cnt_q[i] <= rpt_cnt_q[i] + RPT_W'(1);
`endif
                        end
                    end
                    StDisarming: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= StPressed;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i] <= StIdle;
                            level_q[i] <= 1'b0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: state_q[i] <= StIdle;
                endcase
            end
        end
    end

    // Registered arbiter: keep only the lowest set request bit, drop the rest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_pulse_q <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            sel_pulse_q <= req_q & (~req_q + 4'd1);
            sel_valid_q <= |req_q;
        end
    end

    assign bus.btn_level = level_q;
    assign bus.sel_pulse = sel_pulse_q;
    assign bus.sel_valid = sel_valid_q;

endmodule

// File: tb/tb_btn_debounce_onehot.sv
// Directed bench for btn_debounce_onehot with CNT_MAX=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_btn_debounce_onehot;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    btn_debounce_onehot_if bus ();

    btn_debounce_onehot #(
        .CNT_MAX       (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_level,
                       input logic [3:0] exp_pulse);
        checks++;
        assert (bus.btn_level === exp_level) else begin
            errors++;
            $error("FAIL %s btn_level: got %b want %b", tag, bus.btn_level, exp_level);
        end
        checks++;
        assert (bus.sel_pulse === exp_pulse) else begin
            errors++;
            $error("FAIL %s sel_pulse: got %b want %b", tag, bus.sel_pulse, exp_pulse);
        end
        checks++;
        assert (bus.sel_valid === (|exp_pulse)) else begin
            errors++;
            $error("FAIL %s sel_valid: got %b want %b", tag, bus.sel_valid, |exp_pulse);
        end
    endtask

    logic [3:0] exp_p;
    logic [6:0] bounce;

    initial begin
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b0;
        bus.btn_in  = 4'b1111;

        // Reset held with all buttons pressed: everything stays cleared.
        tick(); tick(); tick();
        chk("reset_hold", 4'b0000, 4'b0000);

        // Release reset; tick k lands just after edge t+k, t = first edge after release.
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("reset_release", (k >= 6) ? 4'b1111 : 4'b0000,
                (k == 7) ? 4'b0001 : 4'b0000);
        end
        bus.btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("reset_release_off", (k < 6) ? 4'b1111 : 4'b0000, 4'b0000);
        end

        // Clean press on button 2, held 20 cycles.
        bus.btn_in = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("clean_press", (k >= 6) ? 4'b0100 : 4'b0000,
                (k == 7) ? 4'b0100 : 4'b0000);
        end
        bus.btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("clean_release", (k < 6) ? 4'b0100 : 4'b0000, 4'b0000);
        end

        // Bounce on button 1: 1,1,0,1,1,1,0 (first value applied first).
        bounce = 7'b0111011;
        for (int k = 0; k < 7; k++) begin
            bus.btn_in = {2'b00, bounce[k], 1'b0};
            tick();
            chk("bounce", 4'b0000, 4'b0000);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bounce_settle", 4'b0000, 4'b0000);
        end
        bus.btn_in = 4'b0010;
        for (int k = 0; k < 14; k++) begin
            tick();
            chk("bounce_hold", (k >= 6) ? 4'b0010 : 4'b0000,
                (k == 7) ? 4'b0010 : 4'b0000);
        end
        bus.btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bounce_release", (k < 6) ? 4'b0010 : 4'b0000, 4'b0000);
        end

        // Simultaneous press of buttons 1 and 3: only the lower index pulses.
        bus.btn_in = 4'b1010;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("simul", (k >= 6) ? 4'b1010 : 4'b0000,
                (k == 7) ? 4'b0010 : 4'b0000);
        end
        bus.btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("simul_release", (k < 6) ? 4'b1010 : 4'b0000, 4'b0000);
        end

        // Reset mid-count on button 3; full qualification restarts after release.
        bus.btn_in = 4'b1000;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("midcount_reset", 4'b0000, 4'b0000);
        tick(); tick();
        chk("midcount_reset_hold", 4'b0000, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("midcount_release", (k >= 6) ? 4'b1000 : 4'b0000,
                (k == 7) ? 4'b1000 : 4'b0000);
        end
        bus.btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("midcount_off", (k < 6) ? 4'b1000 : 4'b0000, 4'b0000);
        end

        // Long hold on button 0: one pulse, plus repeats when the feature is built in.
        bus.btn_in = 4'b0001;
        for (int k = 0; k < 39; k++) begin
            tick();
            exp_p = (k == 7) ? 4'b0001 : 4'b0000;
`ifdef AUTO_REPEAT_EN
            if (k == 17 || k == 22 || k == 27 || k == 32 || k == 37) exp_p = 4'b0001;
`endif
            chk("long_hold", (k >= 6) ? 4'b0001 : 4'b0000, exp_p);
        end
        bus.btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("long_release", (k < 6) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
